// File: rtl/led_pwm_ctrl_pkg.sv
// Shared definitions for the memory-mapped LED PWM controller: register
// offsets, channel mode encodings and the byte-strobe merge helper.
package led_pwm_ctrl_pkg;

  // Low address bits that select a register inside the 256-byte window.
  localparam int WIN_BITS = 8;

  localparam logic [WIN_BITS-1:0] REG_PRESCALE = 8'h00;
  localparam logic [WIN_BITS-1:0] REG_BLINK    = 8'h04;
  localparam logic [WIN_BITS-1:0] REG_STATUS   = 8'h08;
  localparam logic [WIN_BITS-1:0] REG_CH0      = 8'h10;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wstrb);
    logic [31:0] result;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = wstrb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: mode, duty shadow, period-aligned active duty and the
// registered LED output.
module led_pwm_channel
  import led_pwm_ctrl_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_strb,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  input  logic                blink_phase,
  output logic [31:0]         cfg,
  output logic                led
);

  mode_e               mode;
  logic [PWM_BITS-1:0] duty_shadow;
  logic [PWM_BITS-1:0] active_duty;
  logic [31:0]         wr_merged;
  logic                below_duty;
  logic                led_next;
  logic                unused_wr_bits;

  always_comb begin
    cfg                  = '0;
    cfg[1:0]             = mode;
    cfg[8 +: PWM_BITS]   = duty_shadow;
  end

  assign wr_merged      = merge_wstrb(cfg, wr_data, wr_strb);
  assign unused_wr_bits = ^wr_merged;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode        <= MODE_OFF;
      duty_shadow <= '0;
      active_duty <= '0;
      led         <= 1'b0;
    end else begin
      if (wr_en) begin
        mode        <= mode_e'(wr_merged[1:0]);
        duty_shadow <= wr_merged[8 +: PWM_BITS];
      end
      // A write landing on period_end still loads the previous shadow here;
      // the new duty waits for the following period.
      if (period_end) begin
        active_duty <= duty_shadow;
      end
      led <= led_next;
    end
  end

  assign below_duty = (pwm_cnt < active_duty);

  always_comb begin
    led_next = 1'b0;
    case (mode)
      MODE_OFF:   led_next = 1'b0;
      MODE_ON:    led_next = 1'b1;
      MODE_PWM:   led_next = below_duty;
      MODE_BLINK: led_next = blink_phase & below_duty;
      default:    led_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED controller on the PicoRV32 native memory bus: shared
// prescaler, PWM period counter and blink timer feeding NUM_CH channels.
module led_pwm_ctrl
  import led_pwm_ctrl_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          PWM_BITS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [NUM_CH-1:0] led
);

  logic                 sel;
  logic                 req;
  logic                 wr_commit;
  logic [WIN_BITS-1:0]  offset;
  logic [WIN_BITS-3:0]  word_idx;
  logic [NUM_CH-1:0]    ch_hit;
  logic [NUM_CH-1:0]    ch_wr;
  logic [31:0]          ch_cfg [NUM_CH];
  logic [31:0]          rd_word;

  logic [15:0]          prescale;
  logic [15:0]          pre_cnt;
  logic [15:0]          blink;
  logic [15:0]          blink_cnt;
  logic                 blink_phase;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 tick;
  logic                 period_end;
  logic                 prescale_wr;
  logic                 blink_wr;
  logic [31:0]          prescale_merged;
  logic [31:0]          blink_merged;
  logic                 unused_bits;

  // ---------------------------------------------------------------- decode
  assign sel      = mem_valid && (mem_addr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign word_idx = mem_addr[WIN_BITS-1:2];
  assign offset   = {word_idx, 2'b00};

  // The first valid cycle is the request; the following cycle acknowledges
  // and is the one in which a write takes effect.
  assign req       = sel && !mem_ready;
  assign wr_commit = sel && mem_ready && (mem_wstrb != 4'b0000);

  assign prescale_wr = wr_commit && (offset == REG_PRESCALE);
  assign blink_wr    = wr_commit && (offset == REG_BLINK);

  assign prescale_merged = merge_wstrb({16'h0000, prescale}, mem_wdata, mem_wstrb);
  assign blink_merged    = merge_wstrb({16'h0000, blink}, mem_wdata, mem_wstrb);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path can leave it unassigned and infer a latch.
    ch_hit = '0;
    ch_wr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (word_idx == (REG_CH0[WIN_BITS-1:2] + 6'(i)));
      ch_wr[i]  = wr_commit && ch_hit[i];
    end
  end

  always_comb begin
    rd_word = '0;
    if (offset == REG_PRESCALE) begin
      rd_word = {16'h0000, prescale};
    end else if (offset == REG_BLINK) begin
      rd_word = {16'h0000, blink};
    end else if (offset == REG_STATUS) begin
      rd_word = 32'(led);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
        rd_word = ch_cfg[i];
      end
    end
  end

  // ------------------------------------------------------------ bus handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      mem_ready <= req;
      mem_rdata <= req ? rd_word : 32'h0000_0000;
    end
  end

  // ----------------------------------------------------- timebase registers
  assign tick       = (pre_cnt == prescale);
  assign period_end = tick && (&pwm_cnt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescale <= '0;
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
    end else begin
      if (prescale_wr) begin
        prescale <= prescale_merged[15:0];
      end
      // A PRESCALE write restarts the prescaler, but a coincident tick still
      // advances the PWM counter below.
      if (prescale_wr || tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 16'd1;
      end
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (blink_wr) begin
        blink     <= blink_merged[15:0];
        blink_cnt <= '0;
      end else if (period_end) begin
        if (blink_cnt == blink) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- channels
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk         (clk),
      .resetn      (resetn),
      .wr_en       (ch_wr[i]),
      .wr_data     (mem_wdata),
      .wr_strb     (mem_wstrb),
      .pwm_cnt     (pwm_cnt),
      .period_end  (period_end),
      .blink_phase (blink_phase),
      .cfg         (ch_cfg[i]),
      .led         (led[i])
    );
  end

  assign unused_bits = ^{mem_addr[1:0], prescale_merged[31:16], blink_merged[31:16]};

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: register vector table followed by
// multi-cycle PWM, duty-shadow, blink and reset-during-access sequences.
module tb_led_pwm_ctrl;

  localparam int          NUM_CH   = 4;
  localparam int          PWM_BITS = 8;
  localparam logic [31:0] BASE     = 32'h1000_0000;

  localparam logic [31:0] A_PRESCALE = BASE + 32'h00;
  localparam logic [31:0] A_BLINK    = BASE + 32'h04;
  localparam logic [31:0] A_STATUS   = BASE + 32'h08;
  localparam logic [31:0] A_HOLE     = BASE + 32'h0C;
  localparam logic [31:0] A_CH0      = BASE + 32'h10;
  localparam logic [31:0] A_CH1      = BASE + 32'h14;
  localparam logic [31:0] A_CH2      = BASE + 32'h18;
  localparam logic [31:0] A_CH3      = BASE + 32'h1C;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              mem_valid = 1'b0;
  logic [31:0]       mem_addr = '0;
  logic [31:0]       mem_wdata = '0;
  logic [3:0]        mem_wstrb = '0;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic [NUM_CH-1:0] led;

  int n_checks = 0;
  int n_fail   = 0;

  logic hist [4096];

  led_pwm_ctrl #(
    .NUM_CH    (NUM_CH),
    .PWM_BITS  (PWM_BITS),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .led       (led)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One PicoRV32-style access; valid is held through the ready cycle edge.
  task automatic bus(input  logic [31:0] addr,
                     input  logic [31:0] wdata,
                     input  logic [3:0]  strb,
                     output logic [31:0] rdata,
                     output logic        ack,
                     output int          lat);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
    ack   = 1'b0;
    lat   = 0;
    rdata = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        ack   = 1'b1;
        lat   = i;
        rdata = mem_rdata;
        break;
      end
    end
    if (ack) begin
      @(posedge clk);
      #1;
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input string name);
    logic [31:0] rd;
    logic        ack;
    int          lat;
    bus(addr, wdata, 4'hF, rd, ack, lat);
    check({name, "_ack"}, 32'(ack), 32'd1);
  endtask

  task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    logic        ack;
    int          lat;
    bus(addr, 32'h0, 4'h0, rd, ack, lat);
    check({name, "_ack"}, 32'(ack), 32'd1);
    check({name, "_rdata"}, rd, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] rd;
    logic        ack;
    int          lat;
    int          cnt;
    int          c0;
    int          c1;
    logic        prev;
    logic        found;
    int          run_len;
    logic        run_val;
    int          max_low;
    int          max_high;
    int          ones;

    // ------------------------------------------------------------- reset
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led), 32'h0);
    check("reset_ready", 32'(mem_ready), 32'h0);
    check("reset_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;

    // ------------------------------------------------------ register table
    vecs.push_back('{A_STATUS,        32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{A_CH0,           32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{A_PRESCALE,      32'hABCD_1234, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_PRESCALE,      32'h0,         4'h0, 32'h0000_1234, 1'b1});
    vecs.push_back('{A_BLINK,         32'hFFFF_5AFF, 4'h2, 32'h0,         1'b1});
    vecs.push_back('{A_BLINK,         32'h0,         4'h0, 32'h0000_5A00, 1'b1});
    vecs.push_back('{A_CH3,           32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_CH3,           32'h0,         4'h0, 32'h0000_FF03, 1'b1});
    vecs.push_back('{A_CH2,           32'h0000_2002, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_CH2,           32'hFFFF_FF03, 4'h1, 32'h0,         1'b1});
    vecs.push_back('{A_CH2,           32'h0,         4'h0, 32'h0000_2003, 1'b1});
    vecs.push_back('{A_HOLE,          32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{A_HOLE,          32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_HOLE,          32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{BASE + 32'h50,   32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{BASE + 32'h100,  32'h0,         4'h0, 32'h0,         1'b0});
    vecs.push_back('{BASE + 32'h110,  32'h0000_0001, 4'hF, 32'h0,         1'b0});
    vecs.push_back('{A_CH0,           32'h0,         4'h0, 32'h0000_0000, 1'b1});
    vecs.push_back('{A_CH0,           32'h0000_0001, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_STATUS,        32'h0,         4'h0, 32'h0000_0001, 1'b1});
    vecs.push_back('{A_PRESCALE,      32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_BLINK,         32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_CH3,           32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_CH2,           32'h0,         4'hF, 32'h0,         1'b1});
    vecs.push_back('{A_CH0,           32'h0,         4'hF, 32'h0,         1'b1});

    foreach (vecs[i]) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, ack, lat);
      check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      if (i == 0) check("first_read_latency", 32'(lat), 32'd1);
      if (vecs[i].strb == 4'h0 && vecs[i].exp_ack) begin
        check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      end
    end

    // ------------------------------------ PWM, PRESCALE=0, duty 64 of 256
    wr(A_CH0, 32'h0000_4002, "ch0_pwm64");
    repeat (600) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      cnt = 0;
      repeat (256) begin
        @(negedge clk);
        if (led[0]) cnt++;
      end
      check($sformatf("pwm64_period%0d", w), 32'(cnt), 32'd64);
    end

    // ------------------------------ duty change mid-period is shadowed
    found = 1'b0;
    prev  = led[0];
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (led[0] && !prev) begin
        found = 1'b1;
        break;
      end
      prev = led[0];
    end
    check("period_start_found", 32'(found), 32'd1);
    if (found) begin
      c0 = 0;
      c1 = 0;
      fork
        begin
          for (int k = 0; k < 512; k++) begin
            if (k > 0) @(negedge clk);
            if (led[0]) begin
              if (k < 256) c0++;
              else         c1++;
            end
          end
        end
        begin
          repeat (10) @(negedge clk);
          wr(A_CH0, 32'h0000_8002, "ch0_pwm128");
        end
      join
      check("shadow_current_period", 32'(c0), 32'd64);
      check("shadow_next_period", 32'(c1), 32'd128);
    end

    // ------------------- blink: PRESCALE=1, BLINK=1, CH1 blink duty 255
    wr(A_PRESCALE, 32'h0000_0001, "prescale1");
    wr(A_BLINK,    32'h0000_0001, "blink1");
    wr(A_CH1,      32'h0000_FF03, "ch1_blink");
    repeat (1200) @(negedge clk);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      hist[i] = led[1];
    end
    max_low  = 0;
    max_high = 0;
    ones     = 0;
    run_len  = 0;
    run_val  = hist[0];
    for (int i = 0; i < 4096; i++) begin
      if (i < 2048 && hist[i]) ones++;
      if (hist[i] == run_val) begin
        run_len++;
      end else begin
        run_val = hist[i];
        run_len = 1;
      end
      if (run_val && run_len > max_high) max_high = run_len;
      if (!run_val && run_len > max_low) max_low = run_len;
    end
    check("blink_off_run", 32'(max_low), 32'd1026);
    check("blink_on_run", 32'(max_high), 32'd510);
    check("blink_ones_per_cycle", 32'(ones), 32'd1020);

    // ------------------------------------------ reset in the ready cycle
    wr(A_CH0, 32'h0000_0001, "ch0_on");
    repeat (2) @(negedge clk);
    check("ch0_on_led", 32'(led[0]), 32'd1);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = A_CH3;
    mem_wdata = 32'h0000_FF01;
    mem_wstrb = 4'hF;
    @(posedge clk);
    #2;
    check("pre_reset_ready", 32'(mem_ready), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_reset_ready", 32'(mem_ready), 32'd0);
    check("async_reset_led", 32'(led), 32'd0);
    check("async_reset_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rd_check(A_CH3, 32'h0, "lost_write_ch3");
    rd_check(A_CH0, 32'h0, "after_reset_ch0");
    rd_check(A_PRESCALE, 32'h0, "after_reset_prescale");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
